// File: rtl/vend_controller.sv
// Vending transaction sequencer: product selection, coin credit, dispense handshake,
// change/refund, per-product stock, cancel and inactivity timeout.
module vend_controller #(
    parameter int unsigned PRICE_CANDY = 1,
    parameter int unsigned PRICE_CAKE  = 2,
    parameter int unsigned PRICE_DRINK = 3,
    parameter int unsigned STOCK_INIT  = 4,
    parameter int unsigned TIMEOUT     = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel_product,
    input  logic [1:0] coin,
    input  logic       cancel,
    input  logic       restock,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic [1:0] disp_item,
    output logic       change_valid,
    output logic [2:0] change_units,
    output logic [2:0] credit,
    output logic [2:0] sold_out,
    output logic       busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_REFUND
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    stock   [4];
    logic [3:0]    stock_d [4];

    logic          disp_req_d, change_valid_d, busy_d;
    logic [1:0]    disp_item_d;
    logic [2:0]    change_units_d, credit_d, sold_out_d;

    logic [2:0]    coin_val, price, sum_sat, rem;
    logic [3:0]    sum;
    logic          coin_any, sel_ok, timer_exp, paid;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = 3'd1;
            2'b10:   coin_val = 3'd2;
            2'b11:   coin_val = 3'd4;
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        price = '0;
        case (disp_item)
            2'b01:   price = 3'(PRICE_CANDY);
            2'b10:   price = 3'(PRICE_CAKE);
            2'b11:   price = 3'(PRICE_DRINK);
            default: price = '0;
        endcase
    end

    // Coins keep arriving during DISPENSE, so the running sum saturates at the 3-bit maximum.
    assign coin_any  = (coin != 2'b00);
    assign sum       = {1'b0, credit} + {1'b0, coin_val};
    assign sum_sat   = sum[3] ? 3'd7 : sum[2:0];
    assign paid      = coin_any && (sum >= {1'b0, price});
    assign rem       = sum_sat - price;
    assign sel_ok    = (sel_product != 2'b00) && (stock[sel_product] != 4'd0);
    assign timer_exp = !coin_any && (timer <= TW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            for (int unsigned i = 0; i < 4; i++) stock[i] <= 4'(STOCK_INIT);
            disp_req     <= 1'b0;
            disp_item    <= '0;
            change_valid <= 1'b0;
            change_units <= '0;
            credit       <= '0;
            sold_out     <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            stock        <= stock_d;
            disp_req     <= disp_req_d;
            disp_item    <= disp_item_d;
            change_valid <= change_valid_d;
            change_units <= change_units_d;
            credit       <= credit_d;
            sold_out     <= sold_out_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (sel_ok) state_d = S_COLLECT;
            S_COLLECT: begin
                if (paid)                  state_d = S_DISPENSE;
                else if (cancel)           state_d = S_REFUND;
                else if (timer_exp)        state_d = S_REFUND;
            end
            S_DISPENSE: if (disp_ack) state_d = (rem != 3'd0) ? S_REFUND : S_IDLE;
            S_REFUND:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d        = timer;
        stock_d        = stock;
        credit_d       = credit;
        disp_item_d    = disp_item;
        change_valid_d = 1'b0;
        change_units_d = '0;
        case (state)
            S_IDLE: begin
                if (restock) for (int unsigned i = 0; i < 4; i++) stock_d[i] = 4'(STOCK_INIT);
                if (coin_any) begin
                    change_valid_d = 1'b1;
                    change_units_d = coin_val;
                end
                if (sel_ok) begin
                    disp_item_d = sel_product;
                    timer_d     = TW'(TIMEOUT);
                end
            end
            S_COLLECT: begin
                credit_d = sum[2:0];
                if (coin_any)              timer_d = TW'(TIMEOUT);
                else if (timer != '0)      timer_d = timer - TW'(1);
                if (state_d == S_REFUND) begin
                    change_valid_d = 1'b1;
                    change_units_d = sum[2:0];
                    credit_d       = '0;
                end
            end
            S_DISPENSE: begin
                credit_d = sum_sat;
                if (disp_ack) begin
                    if (stock[disp_item] != 4'd0) stock_d[disp_item] = stock[disp_item] - 4'd1;
                    credit_d = rem;
                    if (rem != 3'd0) begin
                        change_valid_d = 1'b1;
                        change_units_d = rem;
                        credit_d       = '0;
                    end
                end
            end
            S_REFUND: begin
                credit_d = '0;
                if (coin_any) begin
                    change_valid_d = 1'b1;
                    change_units_d = coin_val;
                end
            end
            default: credit_d = '0;
        endcase
        if (state_d == S_IDLE) disp_item_d = '0;
    end

    always_comb begin
        disp_req_d = (state_d == S_DISPENSE);
        busy_d     = (state_d != S_IDLE);
        sold_out_d = {stock_d[3] == 4'd0, stock_d[2] == 4'd0, stock_d[1] == 4'd0};
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed, table-driven bench for vend_controller plus hand-written corner sequences.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel_product = '0;
    logic [1:0] coin = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req, change_valid, busy;
    logic [1:0] disp_item;
    logic [2:0] change_units, credit, sold_out;

    int n_cmp = 0;
    int n_bad = 0;

    vend_controller #(
        .PRICE_CANDY(1), .PRICE_CAKE(2), .PRICE_DRINK(3), .STOCK_INIT(4), .TIMEOUT(50)
    ) dut (
        .clk(clk), .rst(rst), .sel_product(sel_product), .coin(coin), .cancel(cancel),
        .restock(restock), .disp_ack(disp_ack), .disp_req(disp_req), .disp_item(disp_item),
        .change_valid(change_valid), .change_units(change_units), .credit(credit),
        .sold_out(sold_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output bundle: {disp_req, disp_item, change_valid, change_units, credit, sold_out, busy}
    function automatic logic [13:0] o(input logic req, input logic [1:0] item, input logic cv,
                                      input logic [2:0] units, input logic [2:0] cr,
                                      input logic [2:0] so, input logic bz);
        return {req, item, cv, units, cr, so, bz};
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  coin;
        logic        cancel;
        logic        restock;
        logic        ack;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [13:0] e);
        logic [13:0] a;
        a = {disp_req, disp_item, change_valid, change_units, credit, sold_out, busy};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got req/item/cv/units/credit/so/busy=%b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b",
                     nm, a[13], a[12:11], a[10], a[9:7], a[6:4], a[3:1], a[0],
                     e[13], e[12:11], e[10], e[9:7], e[6:4], e[3:1], e[0]);
        end
    endtask

    task automatic step(input logic [1:0] s, input logic [1:0] c, input logic ca,
                        input logic rs, input logic ak);
        sel_product = s; coin = c; cancel = ca; restock = rs; disp_ack = ak;
        @(posedge clk);
        #1;
        sel_product = '0; coin = '0; cancel = 1'b0; restock = 1'b0; disp_ack = 1'b0;
    endtask

    function automatic vec_t v(input logic [1:0] s, input logic [1:0] c, input logic ca,
                               input logic rs, input logic ak, input logic [13:0] e);
        vec_t r;
        r.sel = s; r.coin = c; r.cancel = ca; r.restock = rs; r.ack = ak; r.exp = e;
        return r;
    endfunction

    initial begin
        // Cake: two Rs.5 coins, exact price, no change.
        vecs.push_back(v(2'd2, 2'd0, 0, 0, 0, o(0, 2'd2, 0, 3'd0, 3'd0, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd1, 0, 0, 0, o(0, 2'd2, 0, 3'd0, 3'd1, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd1, 0, 0, 0, o(1, 2'd2, 0, 3'd0, 3'd2, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 0, o(1, 2'd2, 0, 3'd0, 3'd2, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 1, o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0)));
        // Candy paid with Rs.20: change of 3 after ack.
        vecs.push_back(v(2'd1, 2'd0, 0, 0, 0, o(0, 2'd1, 0, 3'd0, 3'd0, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd3, 0, 0, 0, o(1, 2'd1, 0, 3'd0, 3'd4, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 1, o(0, 2'd1, 1, 3'd3, 3'd0, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 0, o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0)));
        // Cooldrink cancelled after one coin.
        vecs.push_back(v(2'd3, 2'd0, 0, 0, 0, o(0, 2'd3, 0, 3'd0, 3'd0, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd1, 0, 0, 0, o(0, 2'd3, 0, 3'd0, 3'd1, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 0, o(0, 2'd3, 1, 3'd1, 3'd0, 3'b000, 1)));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 0, o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0)));
        // Three more candies empty the candy stock.
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(v(2'd1, 2'd0, 0, 0, 0, o(0, 2'd1, 0, 3'd0, 3'd0, 3'b000, 1)));
            vecs.push_back(v(2'd0, 2'd1, 0, 0, 0, o(1, 2'd1, 0, 3'd0, 3'd1, 3'b000, 1)));
            vecs.push_back(v(2'd0, 2'd0, 0, 0, 1,
                             o(0, 2'd0, 0, 3'd0, 3'd0, (k == 2) ? 3'b001 : 3'b000, 0)));
        end
        vecs.push_back(v(2'd1, 2'd0, 0, 0, 0, o(0, 2'd0, 0, 3'd0, 3'd0, 3'b001, 0)));
        vecs.push_back(v(2'd0, 2'd0, 0, 1, 0, o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0)));
        // Coin in IDLE refunds itself.
        vecs.push_back(v(2'd0, 2'd2, 0, 0, 0, o(0, 2'd0, 1, 3'd2, 3'd0, 3'b000, 0)));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 0, o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0)));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sel, vecs[i].coin, vecs[i].cancel, vecs[i].restock, vecs[i].ack);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Completing coin together with cancel: dispense wins.
        step(2'd1, 2'd0, 0, 0, 0); chk("pri_sel", o(0, 2'd1, 0, 3'd0, 3'd0, 3'b000, 1));
        step(2'd0, 2'd1, 1, 0, 0); chk("pri_coin_cancel", o(1, 2'd1, 0, 3'd0, 3'd1, 3'b000, 1));
        step(2'd0, 2'd0, 0, 0, 1); chk("pri_ack", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));

        // Coin and cancel during DISPENSE: coin joins the change, cancel ignored.
        step(2'd2, 2'd0, 0, 0, 0); chk("dc_sel", o(0, 2'd2, 0, 3'd0, 3'd0, 3'b000, 1));
        step(2'd0, 2'd2, 0, 0, 0); chk("dc_pay", o(1, 2'd2, 0, 3'd0, 3'd2, 3'b000, 1));
        step(2'd0, 2'd1, 1, 0, 0); chk("dc_extra", o(1, 2'd2, 0, 3'd0, 3'd3, 3'b000, 1));
        step(2'd0, 2'd0, 0, 0, 1); chk("dc_ack", o(0, 2'd2, 1, 3'd1, 3'd0, 3'b000, 1));
        step(2'd0, 2'd0, 0, 0, 0); chk("dc_idle", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));

        // Inactivity timeout: refund on the 50th coinless cycle.
        step(2'd2, 2'd0, 0, 0, 0); chk("to_sel", o(0, 2'd2, 0, 3'd0, 3'd0, 3'b000, 1));
        step(2'd0, 2'd1, 0, 0, 0); chk("to_coin", o(0, 2'd2, 0, 3'd0, 3'd1, 3'b000, 1));
        for (int i = 1; i < 50; i++) begin
            step(2'd0, 2'd0, 0, 0, 0);
            chk($sformatf("to_wait%0d", i), o(0, 2'd2, 0, 3'd0, 3'd1, 3'b000, 1));
        end
        step(2'd0, 2'd0, 0, 0, 0); chk("to_expire", o(0, 2'd2, 1, 3'd1, 3'd0, 3'b000, 1));
        step(2'd0, 2'd0, 0, 0, 0); chk("to_idle", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));

        // Reset in DISPENSE before ack abandons the transaction.
        step(2'd2, 2'd0, 0, 0, 0); chk("rs_sel", o(0, 2'd2, 0, 3'd0, 3'd0, 3'b000, 1));
        step(2'd0, 2'd2, 0, 0, 0); chk("rs_pay", o(1, 2'd2, 0, 3'd0, 3'd2, 3'b000, 1));
        #2 rst = 1'b1;
        #1 chk("rs_async", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));
        @(posedge clk);
        #1 rst = 1'b0;
        step(2'd0, 2'd0, 0, 0, 1); chk("rs_after1", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));
        step(2'd0, 2'd0, 0, 0, 0); chk("rs_after2", o(0, 2'd0, 0, 3'd0, 3'd0, 3'b000, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
